// File: rtl/upf_subtractor_pipe.sv
// Two-stage pipelined subtractor with an exact upper half and a lower half
// split into K blocks, each exact or approximated according to a runtime mask.
module upf_subtractor_pipe #(
  parameter int unsigned N       = 32,
  parameter int unsigned K       = 4,
  parameter logic [K-1:0] CFG_RST = {K{1'b1}}
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cfg_we_i,
  input  logic [K-1:0] cfg_i,
  output logic [K-1:0] cfg_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] d_o,
  output logic         borrow_o
);

  localparam int unsigned H = N / 2;
  localparam int unsigned W = H / K;

  logic [K-1:0] cfg_q;

  logic         s1_valid;
  logic [H-1:0] s1_lo;
  logic         s1_carry;
  logic [H-1:0] s1_a_hi;
  logic [H-1:0] s1_b_hi;

  logic         s2_valid;
  logic [N-1:0] d_q;
  logic         borrow_q;

  logic         s1_adv;
  logic         s2_adv;
  logic         accept;

  logic [H-1:0] lo_diff;
  logic         lo_carry;
  logic [H:0]   hi_sum;

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = s2_adv || !s1_valid;
  assign in_ready_o = s1_adv;
  assign accept     = in_valid_i && in_ready_o;

  assign cfg_o       = cfg_q;
  assign out_valid_o = s2_valid;
  assign d_o         = d_q;
  assign borrow_o    = borrow_q;

  // Lower half: a + ~b + 1 block by block; an approximated block yields zeros
  // and forces its carry out to 1, so it never propagates a borrow upward.
  always_comb begin
    logic       carry;
    logic [W:0] blk;
    lo_diff = '0;
    carry   = 1'b1;
    blk     = '0;
    for (int j = 0; j < int'(K); j++) begin
      if (cfg_q[j]) begin
        blk = {1'b0, a_i[j*W +: W]} + {1'b0, ~b_i[j*W +: W]} + {{W{1'b0}}, carry};
        lo_diff[j*W +: W] = blk[W-1:0];
        carry             = blk[W];
      end else begin
        lo_diff[j*W +: W] = '0;
        carry             = 1'b1;
      end
    end
    lo_carry = carry;
  end

  assign hi_sum = {1'b0, s1_a_hi} + {1'b0, ~s1_b_hi} + {{H{1'b0}}, s1_carry};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= CFG_RST;
    end else if (cfg_we_i) begin
      cfg_q <= cfg_i;
    end
  end

  // Stage 1 captures the lower result using the mask in effect before any
  // same-cycle configuration write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_carry <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_lo    <= lo_diff;
        s1_carry <= lo_carry;
        s1_a_hi  <= a_i[N-1:H];
        s1_b_hi  <= b_i[N-1:H];
      end
    end
  end

  // Stage 2 holds the result stable while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d_q      <= {hi_sum[H-1:0], s1_lo};
        borrow_q <= ~hi_sum[H];
      end
    end
  end

endmodule

// File: tb/tb_upf_subtractor_pipe.sv
// Directed self-checking bench for upf_subtractor_pipe (N=32, K=4).
module tb_upf_subtractor_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cfg_we;
  logic [3:0]  cfg_in;
  logic [3:0]  cfg_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        borrow;

  int checks   = 0;
  int failures = 0;

  upf_subtractor_pipe #(.N(32), .K(4), .CFG_RST(4'b1111)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .cfg_we_i    (cfg_we),
    .cfg_i       (cfg_in),
    .cfg_o       (cfg_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .d_o         (d_out),
    .borrow_o    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one operand pair and waits (bounded) for its result; lat counts
  // edges from the accept edge to the first sample with out_valid high.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic br, output int lat);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = d_out;
    br = borrow;
  endtask

  task automatic write_cfg(input logic [3:0] m);
    cfg_we = 1'b1;
    cfg_in = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (d_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_d got=%h exp=00000000", d_out); end
    checks++;
    if (borrow !== 1'b0) begin failures++; $display("[TB] FAIL reset_borrow got=%b exp=0", borrow); end
    checks++;
    if (cfg_out !== 4'b1111) begin failures++; $display("[TB] FAIL reset_cfg got=%b exp=1111", cfg_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_exact();
    logic [31:0] d;
    logic        br;
    int          lat;
    send_op(32'h0001_0000, 32'h0000_0001, d, br, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("[TB] FAIL exact_latency got=%0d exp=2", lat); end
    checks++;
    if (d !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL exact1_d got=%h exp=0000ffff", d); end
    checks++;
    if (br !== 1'b0) begin failures++; $display("[TB] FAIL exact1_borrow got=%b exp=0", br); end
    send_op(32'h0000_0000, 32'h0000_0001, d, br, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL exact2_d got=%h exp=ffffffff", d); end
    checks++;
    if (br !== 1'b1) begin failures++; $display("[TB] FAIL exact2_borrow got=%b exp=1", br); end
  endtask

  task automatic test_approx_block0();
    logic [31:0] d;
    logic        br;
    int          lat;
    write_cfg(4'b1110);
    checks++;
    if (cfg_out !== 4'b1110) begin failures++; $display("[TB] FAIL approx_cfg got=%b exp=1110", cfg_out); end
    send_op(32'h0001_0000, 32'h0000_0001, d, br, lat);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("[TB] FAIL approx1_d got=%h exp=00010000", d); end
    checks++;
    if (br !== 1'b0) begin failures++; $display("[TB] FAIL approx1_borrow got=%b exp=0", br); end
    send_op(32'h0000_00F7, 32'h0000_0012, d, br, lat);
    checks++;
    if (d !== 32'h0000_00E0) begin failures++; $display("[TB] FAIL approx2_d got=%h exp=000000e0", d); end
  endtask

  task automatic test_cfg_collision();
    logic [31:0] res [2];
    int          got;
    write_cfg(4'b1111);
    @(posedge clk); #1;
    cfg_we   = 1'b1;
    cfg_in   = 4'b0000;
    in_valid = 1'b1;
    a_in     = 32'h0000_0005;
    b_in     = 32'h0000_0003;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_out !== 4'b0000) begin failures++; $display("[TB] FAIL collide_cfg got=%b exp=0000", cfg_out); end
    a_in = 32'h0000_FFFF;
    b_in = 32'h0000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      if (out_valid) begin
        res[got] = d_out;
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 2) begin failures++; $display("[TB] FAIL collide_count got=%0d exp=2", got); end
    else begin
      checks++;
      if (res[0] !== 32'h0000_0002) begin failures++; $display("[TB] FAIL collide_old_mask got=%h exp=00000002", res[0]); end
      checks++;
      if (res[1] !== 32'h0000_0000) begin failures++; $display("[TB] FAIL collide_new_mask got=%h exp=00000000", res[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_a  [4] = '{32'h0000_0010, 32'h0000_1000, 32'h0000_0005, 32'hFFFF_FFFF};
    logic [31:0] op_b  [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0009, 32'hFFFF_FFFF};
    logic [31:0] exp_d [4] = '{32'h0000_000D, 32'h0000_0FFF, 32'hFFFF_FFFC, 32'h0000_0000};
    logic        exp_b [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          tx = 0;
    int          rx = 0;
    logic        saw_stall = 1'b0;
    logic        holding = 1'b0;
    logic [31:0] held_d = '0;
    write_cfg(4'b1111);
    for (int c = 0; c < 40 && rx < 4; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (tx < 4);
      a_in      = (tx < 4) ? op_a[tx] : 32'h0;
      b_in      = (tx < 4) ? op_b[tx] : 32'h0;
      #2;
      if (!in_ready) saw_stall = 1'b1;
      if (holding) begin
        checks++;
        if (out_valid !== 1'b1 || d_out !== held_d) begin
          failures++;
          $display("[TB] FAIL bp_hold got=%b/%h exp=1/%h", out_valid, d_out, held_d);
        end
      end
      holding = out_valid && !out_ready;
      held_d  = d_out;
      if (out_valid && out_ready) begin
        checks++;
        if (d_out !== exp_d[rx] || borrow !== exp_b[rx]) begin
          failures++;
          $display("[TB] FAIL bp_result%0d got=%h/%b exp=%h/%b", rx, d_out, borrow, exp_d[rx], exp_b[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rx !== 4) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=4", rx); end
    checks++;
    if (saw_stall !== 1'b1) begin failures++; $display("[TB] FAIL bp_in_ready_stall got=%b exp=1", saw_stall); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic        br;
    int          lat;
    logic        stale = 1'b0;
    write_cfg(4'b0101);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 32'h0000_0100;
    b_in      = 32'h0000_0001;
    @(posedge clk); #1;
    a_in = 32'h0000_0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_inflight got=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (d_out !== 32'h0) begin failures++; $display("[TB] FAIL mid_d got=%h exp=00000000", d_out); end
    checks++;
    if (cfg_out !== 4'b1111) begin failures++; $display("[TB] FAIL mid_cfg got=%b exp=1111", cfg_out); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale_valid got=%b exp=0", stale); end
    send_op(32'h0000_0100, 32'h0000_0001, d, br, lat);
    checks++;
    if (d !== 32'h0000_00FF || lat !== 2) begin
      failures++;
      $display("[TB] FAIL mid_after_release got=%h lat=%0d exp=000000ff lat=2", d, lat);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cfg_we    = 1'b0;
    cfg_in    = '0;
    out_ready = 1'b1;
    test_reset();
    test_exact();
    test_approx_block0();
    test_cfg_collision();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upf_subtractor_pipe.md
Name: upf_subtractor_pipe

Overview:
- Pipelined, runtime-configurable approximate subtractor; the inverse-operation companion to the team's upper-accurate/lower-approximate adder.
- Computes d = a - b. The upper N/2 bits are always exact. The lower N/2 bits are split into K blocks, and each block is exact or approximated per a configuration register.
- Two-stage pipeline with valid/ready handshake on both sides.
- Used in accuracy/energy exploration datapaths, where the approximation mask is reprogrammed between workloads.

Parameters:
- N, 32, operand width; even, and N/2 divisible by K.
- K, 4, number of lower-half blocks; block width W = N/(2K).
- CFG_RST, 4'b1111, reset value of the K-bit approximation mask; bit j = 1 means block j is exact.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept an operand pair.
- a_i  in  N  minuend.
- b_i  in  N  subtrahend.
- cfg_we_i  in  1  load cfg_i into the mask register.
- cfg_i  in  K  new approximation mask.
- cfg_o  out  K  current mask register.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- d_o  out  N  difference.
- borrow_o  out  1  borrow out of bit N-1; 1 when an unsigned underflow occurs in the computed result.

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - both stage-valid flags = 0, so out_valid_o = 0.
  - d_o = 0, borrow_o = 0.
  - mask register = CFG_RST.
  - in_ready_o = 1 once reset is released.
- Arithmetic:
  - Computed as a + ~b + 1 through a carry chain; carry into block 0 is 1.
  - Exact block j: ripple over bits [W*(j+1)-1 : W*j]; carry out is the true carry.
  - Approximated block j: its difference bits are 0 and its carry out is 1 (no borrow). Its carry in is ignored.
  - Upper half: exact N/2-bit ripple with carry in = carry out of block K-1.
  - borrow_o = NOT(final carry).
- Pipeline:
  - Stage 1 register captures the lower N/2 result, the carry into the upper half, and a[N-1:N/2], b[N-1:N/2].
  - Stage 2 register holds d_o and borrow_o.
  - Latency: 2 cycles from the accept edge to out_valid_o, when there is no backpressure.
  - Throughput: 1 result per cycle.
- Handshake:
  - Input transfer occurs when in_valid_i & in_ready_o.
  - Output transfer occurs when out_valid_o & out_ready_i.
  - Stage 2 advances when it is empty or out_ready_i = 1. Stage 1 advances when stage 2 advances or stage 1 is empty.
  - in_ready_o = stage-1 empty OR stage 1 advancing. This is combinational from out_ready_i; there are no bubbles under full throughput.
  - While out_valid_o = 1 and out_ready_i = 0, d_o and borrow_o are held stable.
  - Stage contents never drop or duplicate.
- Configuration:
  - The mask is applied at stage-1 capture only. In-flight operations keep the mask they were accepted with.
  - If cfg_we_i and an input transfer occur in the same cycle, the accepted operand uses the OLD mask. The new mask applies from the next cycle.
  - cfg_o reflects the register value, updated on the edge after cfg_we_i.
- Reset mid-operation: all in-flight results are discarded and no stale out_valid_o appears after release.
- No X propagation: output registers only load when valid.

Test Plan:
- Exact mode:
  - mask 4'b1111, a = 0x0001_0000, b = 0x0000_0001 -> after 2 cycles d_o = 0x0000_FFFF, borrow_o = 0.
  - mask 4'b1111, a = 0, b = 1 -> d_o = 0xFFFF_FFFF, borrow_o = 1.
- Approximate block 0: cfg write 4'b1110, then a = 0x0001_0000, b = 0x0000_0001 -> d_o = 0x0001_0000, borrow_o = 0.
  - Repeat with a = 0x0000_00F7, b = 0x0000_0012 -> d_o = 0x0000_00E0.
- Config/accept collision: cfg_we_i = 1 with cfg_i = 4'b0000 in the same cycle as accepting a = 0x0000_0005, b = 0x0000_0003 (mask 4'b1111) -> d_o = 0x0000_0002. The next operand a = 0x0000_FFFF, b = 0 -> d_o = 0x0000_0000.
- Backpressure: stream 4 operand pairs back-to-back with out_ready_i = 0 for cycles 3-6 -> in_ready_o deasserts once both stages are full, d_o is held stable, and all 4 results appear in order with none lost or duplicated.
- Reset mid-flight: assert rst_ni = 0 asynchronously with 2 operations in flight -> out_valid_o = 0 immediately and d_o = 0, cfg_o = CFG_RST. After release, no result appears until a new operand pair is accepted.
